// File: rtl/tx_buf_writer_pkg.sv
// Shared definitions for the DMA-side transmit buffer writer: header layout,
// FSM encoding and the byte-to-qword conversion used when sizing a frame.
package tx_buf_writer_pkg;

    localparam int BYTES_LSB = 32;
    localparam int BYTES_MSB = 47;
    localparam int QW_W      = 14;   // ceil(65535/8) = 8192 needs 14 bits

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_DATA   = 3'd2,
        ST_DROP   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    function automatic logic [QW_W-1:0] qword_count(input logic [15:0] bytes);
        return {1'b0, bytes[15:3]} + {{(QW_W-1){1'b0}}, |bytes[2:0]};
    endfunction

    function automatic logic [63:0] make_header(input logic [15:0] bytes);
        logic [63:0] hdr;
        hdr = '0;
        hdr[BYTES_MSB:BYTES_LSB] = bytes;
        return hdr;
    endfunction

endpackage

// File: rtl/tx_buf_writer_ptr_cdc_sync.sv
// Brings a pointer published by another clock domain across with a toggle/level
// change strobe: 2-flop strobe synchroniser, edge register and 2-flop address staging.
module tx_buf_writer_ptr_cdc_sync #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] async_addr,
    input  logic          async_change,
    output logic [AW-1:0] sync_addr
);

    logic          chg_s1;
    logic          chg_s2;
    logic          chg_s3;
    logic [AW-1:0] addr_s1;
    logic [AW-1:0] addr_s2;

    // The sender holds the address for at least two of our cycles after a strobe
    // change, so addr_s2 has settled by the time the edge register sees it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chg_s1    <= 1'b0;
            chg_s2    <= 1'b0;
            chg_s3    <= 1'b0;
            addr_s1   <= '0;
            addr_s2   <= '0;
            sync_addr <= '0;
        end else begin
            chg_s1  <= async_change;
            chg_s2  <= chg_s1;
            chg_s3  <= chg_s2;
            addr_s1 <= async_addr;
            addr_s2 <= addr_s1;
            if (chg_s2 != chg_s3) begin
                sync_addr <= addr_s2;
            end
        end
    end

endmodule

// File: rtl/tx_buf_writer.sv
// DMA-side writer for the MAC transmit buffer: prepends a header qword per frame,
// writes header and payload, and publishes the committed write pointer.
module tx_buf_writer
    import tx_buf_writer_pkg::*;
#(
    parameter int BF        = 9,
    parameter int MAX_BYTES = 9600,
    parameter int UPD_HOLD  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [63:0]   in_data,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          in_eof,
    input  logic [15:0]   in_bytes,
    output logic          in_ready,
    output logic [BF:0]   mem_wr_addr,
    output logic [63:0]   mem_wr_data,
    output logic          mem_wr_en,
    output logic [BF:0]   wr_addr,
    output logic          wr_addr_updated,
    input  logic [BF:0]   commited_rd_address,
    input  logic          commited_rd_address_change,
    output logic [15:0]   drop_count
);

    localparam int          AW    = BF + 1;
    localparam int          HW    = $clog2(UPD_HOLD + 1);
    localparam logic [15:0] MAX_B = 16'(MAX_BYTES);

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   frame_start;
    logic [AW-1:0]   rd_ptr_sync;
    logic [15:0]     bytes_q;
    logic [QW_W-1:0] qwords_q;
    logic [QW_W-1:0] beat_cnt;
    logic [QW_W-1:0] beat_cnt_inc;
    logic [HW-1:0]   hold_cnt;
    logic [AW-1:0]   used;
    logic [AW-1:0]   free;
    logic [15:0]     need;
    logic            last_beat;

    logic            latch_frame;
    logic            hdr_wr;
    logic            beat_acc;
    logic            do_rewind;
    logic            do_commit;
    logic            drop_inc;

    tx_buf_writer_ptr_cdc_sync #(
        .AW (AW)
    ) u_rd_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .async_addr   (commited_rd_address),
        .async_change (commited_rd_address_change),
        .sync_addr    (rd_ptr_sync)
    );

    // One slot stays empty so wr_ptr == rd_ptr always means empty.
    assign used         = wr_ptr - rd_ptr_sync;
    assign free         = {AW{1'b1}} - used;
    assign need         = 16'(qwords_q) + 16'd1;
    assign beat_cnt_inc = beat_cnt + QW_W'(1);
    assign last_beat    = (beat_cnt_inc == qwords_q);
    assign mem_wr_addr  = wr_ptr;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        latch_frame = 1'b0;
        hdr_wr      = 1'b0;
        beat_acc    = 1'b0;
        do_rewind   = 1'b0;
        do_commit   = 1'b0;
        drop_inc    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    latch_frame = 1'b1;
                    if (in_bytes == 16'd0 || in_bytes > MAX_B) begin
                        drop_inc   = 1'b1;
                        state_next = ST_DROP;
                    end else begin
                        state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (16'(free) >= need) begin
                    hdr_wr      = 1'b1;
                    mem_wr_en   = 1'b1;
                    mem_wr_data = make_header(bytes_q);
                    state_next  = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_acc    = 1'b1;
                    mem_wr_en   = 1'b1;
                    mem_wr_data = in_data;
                    if (last_beat && in_eof) begin
                        state_next = ST_COMMIT;
                    end else if (last_beat || in_eof) begin
                        // Length disagrees with the header: abandon the frame in place.
                        do_rewind  = 1'b1;
                        drop_inc   = 1'b1;
                        state_next = in_eof ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_eof) begin
                    state_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (hold_cnt == '0) begin
                    do_commit  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            wr_ptr          <= '0;
            frame_start     <= '0;
            bytes_q         <= '0;
            qwords_q        <= '0;
            beat_cnt        <= '0;
            hold_cnt        <= '0;
            wr_addr         <= '0;
            wr_addr_updated <= 1'b0;
            drop_count      <= '0;
        end else begin
            state <= state_next;

            if (latch_frame) begin
                bytes_q  <= in_bytes;
                qwords_q <= qword_count(in_bytes);
            end

            if (hdr_wr) begin
                frame_start <= wr_ptr;
                wr_ptr      <= wr_ptr + AW'(1);
                beat_cnt    <= '0;
            end else if (do_rewind) begin
                wr_ptr <= frame_start;
            end else if (beat_acc) begin
                wr_ptr   <= wr_ptr + AW'(1);
                beat_cnt <= beat_cnt_inc;
            end

            if (drop_inc && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end

            // The qualifier is a flop so the MAC side samples a glitch-free level.
            if (do_commit) begin
                wr_addr         <= wr_ptr;
                hold_cnt        <= HW'(UPD_HOLD);
                wr_addr_updated <= 1'b1;
            end else begin
                if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - HW'(1);
                end
                wr_addr_updated <= (hold_cnt > HW'(1));
            end
        end
    end

endmodule
